// File: rtl/vlc_tx_sched.sv
// VLC transmit frame scheduler: round-robin arbiter for two requesters plus a frame sequencer.
// Optional checksum byte enabled by defining VLC_TX_CHECKSUM_EN.
module vlc_tx_sched #(
  parameter int PREAMBLE_LEN = 4,
  parameter int MAX_LEN      = 64,
  parameter int GAP_CYCLES   = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       enable,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [6:0] req0_len,
  input  logic [6:0] req1_len,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_rd,
  output logic       req1_rd,
  output logic       req0_done,
  output logic       req1_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err_len
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_GAP  = 3'd6;

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [6:0] MAX_L    = 7'(MAX_LEN);

  logic [2:0] state;
  logic [3:0] pre_cnt;
  logic [6:0] pay_cnt;
  logic [6:0] len_q;
  logic [7:0] gap_cnt;
  logic [1:0] grant_q;
  logic       last_grant;
  logic [1:0] done_q;
  logic       err_q;
`ifdef VLC_TX_CHECKSUM_EN
  logic [7:0] csum;
`endif

  logic       hs;
  logic [7:0] pay_byte;
  logic       pay_last;
  logic       pick1;
  logic [6:0] win_len;
  logic       len_bad;

  assign hs       = tx_valid & tx_ready;
  assign pay_byte = grant_q[1] ? req1_data : req0_data;
  assign pay_last = (pay_cnt == len_q - 7'd1);

  // last_grant==1 means requester 1 was served last, so requester 0 has priority.
  assign pick1   = req1_valid & (~req0_valid | ~last_grant);
  assign win_len = pick1 ? req1_len : req0_len;
  assign len_bad = (win_len == 7'd0) || (win_len > MAX_L);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      pay_cnt    <= '0;
      len_q      <= '0;
      gap_cnt    <= '0;
      grant_q    <= '0;
      last_grant <= 1'b1;
      done_q     <= '0;
      err_q      <= 1'b0;
`ifdef VLC_TX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && (req0_valid || req1_valid)) begin
            grant_q    <= pick1 ? 2'b10 : 2'b01;
            last_grant <= pick1;
            len_q      <= win_len;
            if (len_bad) begin
              err_q   <= 1'b1;
              done_q  <= pick1 ? 2'b10 : 2'b01;
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              pre_cnt <= '0;
              state   <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (hs) begin
            if (pre_cnt == PRE_LAST) state <= S_SFD;
            else pre_cnt <= pre_cnt + 4'd1;
          end
        end
        S_SFD: if (hs) state <= S_LEN;
        S_LEN: begin
          if (hs) begin
            pay_cnt <= '0;
`ifdef VLC_TX_CHECKSUM_EN
            csum    <= {1'b0, len_q};
`endif
            state   <= S_PAY;
          end
        end
        S_PAY: begin
          if (hs) begin
`ifdef VLC_TX_CHECKSUM_EN
            csum <= csum + pay_byte;
`endif
            if (pay_last) begin
`ifdef VLC_TX_CHECKSUM_EN
              state   <= S_CHK;
`else
              done_q  <= grant_q;
              gap_cnt <= '0;
              state   <= S_GAP;
`endif
            end else begin
              pay_cnt <= pay_cnt + 7'd1;
            end
          end
        end
`ifdef VLC_TX_CHECKSUM_EN
        S_CHK: begin
          if (hs) begin
            done_q  <= grant_q;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
`endif
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            grant_q <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    case (state)
      S_PRE: begin
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        tx_sof   = (pre_cnt == 4'd0);
      end
      S_SFD: begin
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, len_q};
      end
      S_PAY: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
`ifndef VLC_TX_CHECKSUM_EN
        tx_eof   = pay_last;
`endif
      end
`ifdef VLC_TX_CHECKSUM_EN
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = ~csum + 8'd1;
        tx_eof   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign req0_rd   = (state == S_PAY) & tx_ready & grant_q[0];
  assign req1_rd   = (state == S_PAY) & tx_ready & grant_q[1];
  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign grant     = grant_q;
  assign busy      = (state != S_IDLE);
  assign err_len   = err_q;

endmodule

// File: tb/tb_vlc_tx_sched.sv
// Self-checking bench for vlc_tx_sched; expectations follow VLC_TX_CHECKSUM_EN when defined.
module tb_vlc_tx_sched;

  localparam int G = 16;
`ifdef VLC_TX_CHECKSUM_EN
  localparam bit CHK_EN  = 1'b1;
  localparam int FRAME_N = 10;
`else
  localparam bit CHK_EN  = 1'b0;
  localparam int FRAME_N = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_len, req1_len;
  logic [7:0] req0_data, req1_data;
  logic       req0_rd, req1_rd, req0_done, req1_done;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_sof, tx_eof;
  logic [1:0] grant;
  logic       busy, err_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vlc_tx_sched #(
    .PREAMBLE_LEN(4),
    .MAX_LEN     (64),
    .GAP_CYCLES  (G)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .enable       (enable),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_len     (req0_len),
    .req1_len     (req1_len),
    .req0_data    (req0_data),
    .req1_data    (req1_data),
    .req0_rd      (req0_rd),
    .req1_rd      (req1_rd),
    .req0_done    (req0_done),
    .req1_done    (req1_done),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .grant        (grant),
    .busy         (busy),
    .err_len      (err_len)
  );

  // Show-ahead requester FIFOs
  logic [7:0] mem0 [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] mem1 [0:3] = '{8'h51, 8'h62, 8'h73, 8'h84};
  logic [1:0] p0, p1;
  logic       pclr;
  always @(posedge clk) begin
    if (pclr) begin
      p0 <= '0;
      p1 <= '0;
    end else begin
      if (req0_rd) p0 <= p0 + 2'd1;
      if (req1_rd) p1 <= p1 + 2'd1;
    end
  end
  assign req0_data = mem0[p0];
  assign req1_data = mem1[p1];

  logic [7:0] exp_frame [0:9] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hD5,
                                  8'h03, 8'h11, 8'h22, 8'h33, 8'h97};

  typedef struct {
    logic       v0;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       ee;
    logic       erd;
    logic       edone;
    logic       ebusy;
    logic [1:0] eg;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic v0, logic ev, logic [7:0] ed, logic es, logic ee,
                              logic erd, logic edone, logic ebusy, logic [1:0] eg);
    vec_t v;
    v.v0 = v0; v.rdy = 1'b1; v.ev = ev; v.ed = ed; v.es = es; v.ee = ee;
    v.erd = erd; v.edone = edone; v.ebusy = ebusy; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clr_ptr();
    pclr = 1'b1;
    tick();
    pclr = 1'b0;
  endtask

  // Counts busy cycles from the current cycle on; returns with busy low or bound expired.
  task automatic busy_run(output int n);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      tick();
    end
    tick();
  endtask

  task automatic do_reject(input logic [6:0] l, input string tag);
    int ne, nd, nb, nv;
    ne = 0; nd = 0; nb = 0; nv = 0;
    req1_len   = l;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_grant"}, grant, 2'b10);
    chk({tag, "_err_first"}, err_len, 1'b1);
    chk({tag, "_done_first"}, req1_done, 1'b1);
    for (int c = 0; c < 40; c++) begin
      ne += int'(err_len);
      nd += int'(req1_done);
      nb += int'(busy);
      nv += int'(tx_valid);
      tick();
      @(negedge clk);
    end
    tick();
    chk({tag, "_err_count"}, ne, 1);
    chk({tag, "_done_count"}, nd, 1);
    chk({tag, "_busy_cycles"}, nb, G);
    chk({tag, "_tx_valid_count"}, nv, 0);
  endtask

  int n, k, ndone, last_done, hsn, rdn;
  logic [1:0] gseq [0:2];
  logic [1:0] prev_g;
  logic       hold_pend, donef, hit;
  logic [7:0] held;
  logic [7:0] got[$];

  initial begin
    rst_n = 1'b0; enable = 1'b0; pclr = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_len = '0; req1_len = '0; tx_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b1; pclr = 1'b0; enable = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0); chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_sof_eof", {tx_sof, tx_eof}, 2'b00); chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 2'b00); chk("rst_err", err_len, 0);
    chk("rst_rd_done", {req0_rd, req1_rd, req0_done, req1_done}, 4'b0000);
    tick();

    // Contention right after reset: req0, req1, req0
    req0_len = 7'd1; req1_len = 7'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0; ndone = 0; last_done = 0; prev_g = 2'b00;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev_g == 2'b00 && k < 3) begin
        gseq[k] = grant;
        if (k > 0) chk("cont_spacing", c - last_done, G + 1);
        k++;
      end
      if (req0_done || req1_done) begin
        last_done = c;
        ndone++;
      end
      prev_g = grant;
      tick();
      if (ndone == 3) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_done_count", ndone, 3);
    chk("cont_grant0", gseq[0], 2'b01);
    chk("cont_grant1", gseq[1], 2'b10);
    chk("cont_grant2", gseq[2], 2'b01);
    busy_run(n);

    // Single frame, table-driven
    do_reset();
    clr_ptr();
    req0_len = 7'd3;
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'hD5, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'h03, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'h11, 0, 0, 1, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'h22, 0, 0, 1, 0, 1, 2'b01));
    vecs.push_back(mk(1, 1, 8'h33, 0, !CHK_EN, 1, 0, 1, 2'b01));
    if (CHK_EN) vecs.push_back(mk(1, 1, 8'h97, 0, 1, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 2'b01));
    for (int i = 0; i < vecs.size(); i++) begin
      req0_valid = vecs[i].v0;
      tx_ready   = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_tx_valid", i), tx_valid, vecs[i].ev);
      chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].ed);
      chk($sformatf("v%0d_sof_eof", i), {tx_sof, tx_eof}, {vecs[i].es, vecs[i].ee});
      chk($sformatf("v%0d_rd0", i), req0_rd, vecs[i].erd);
      chk($sformatf("v%0d_done0", i), req0_done, vecs[i].edone);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].eg);
      tick();
    end
    busy_run(n);
    chk("single_gap_busy", n + 1, G);

    // Backpressure during payload
    clr_ptr();
    req0_valid = 1'b1; tx_ready = 1'b1;
    hsn = 0; rdn = 0; hold_pend = 1'b0; donef = 1'b0; held = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (hold_pend) chk("bp_stall_stable", tx_data, held);
      hold_pend = tx_valid && !tx_ready;
      held = tx_data;
      if (req0_rd) rdn++;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        hsn++;
      end
      if (req0_done) donef = 1'b1;
      tick();
      if (donef) break;
      tx_ready = (hsn >= 6 && hsn < 9) ? ~tx_ready : 1'b1;
    end
    req0_valid = 1'b0; tx_ready = 1'b1;
    chk("bp_done_seen", donef, 1'b1);
    chk("bp_rd_count", rdn, 3);
    chk("bp_byte_count", got.size(), FRAME_N);
    for (int i = 0; i < FRAME_N; i++)
      if (i < got.size()) chk($sformatf("bp_byte%0d", i), got[i], exp_frame[i]);
    busy_run(n);

    // Length rejects on requester 1
    do_reject(7'd0, "rej0");
    do_reject(7'd100, "rej100");

    // Reset during the second payload byte
    clr_ptr();
    req0_valid = 1'b1; tx_ready = 1'b1; hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      hit = req0_rd;
      tick();
      if (hit) break;
    end
    chk("mid_reached_pay", hit, 1'b1);
    rst_n = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_second_byte", tx_data, 8'h22);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {tx_valid, tx_sof, tx_eof, busy, err_len, req0_rd, req1_rd,
                          req0_done, req1_done}, 9'b0);
    chk("mid_rst_grant_data", {grant, tx_data}, 10'h000);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      ndone += int'(req0_done) + int'(req1_done);
      tick();
      @(negedge clk);
    end
    tick();
    chk("mid_no_done", ndone, 0);
    clr_ptr();
    req0_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_restart_valid", tx_valid, 1'b1);
    chk("mid_restart_data", tx_data, 8'hAA);
    chk("mid_restart_sof", tx_sof, 1'b1);
    chk("mid_restart_grant", grant, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
